// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle signed WIDTH x WIDTH multiply / divide unit.
//
// Sequence: IDLE -> PREP -> RUN (WIDTH cycles) -> FIX -> DONE -> IDLE.
// Only one operation is in flight. The multiply is an LSB-first shift-add on
// the operand magnitudes. The divide is a restoring divide on the magnitudes.
// Signs are applied in FIX, and the divide truncates toward zero.
//
// Ports:
//   iClk      clock, rising edge
//   iRst      synchronous reset, active-high
//   iStart    start request, sampled only in IDLE
//   iOp       0 = MUL, 1 = DIV (sampled with iStart)
//   iRegA     multiplicand / dividend, two's complement
//   iRegB     multiplier / divisor, two's complement
//   oBusy     high in PREP, RUN, FIX
//   oDone     one-cycle completion pulse
//   oHi       MUL: product high word; DIV: remainder
//   oLo       MUL: product low word;  DIV: quotient
//   oDivZero  divide-by-zero flag, pulses with oDone (MDU_DIVZERO_FLAG_EN only)
//
// Build option: define MDU_DIVZERO_FLAG_EN to add oDivZero. It also makes a
// divide by zero finish directly from PREP.

module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iOp,
    input  logic [WIDTH-1:0] iRegA,
    input  logic [WIDTH-1:0] iRegB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oHi,
`ifdef MDU_DIVZERO_FLAG_EN
    output logic [WIDTH-1:0] oLo,
    output logic             oDivZero
`else
    output logic [WIDTH-1:0] oLo
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_op;
    logic                   r_sign_a;
    logic                   r_sign_b;
    logic [WIDTH-1:0]       r_mag_a;
    logic [WIDTH-1:0]       r_mag_b;
    logic [2*WIDTH-1:0]     r_acc;
    logic [CNT_W-1:0]       r_count;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;
    logic                   w_dz_fast;

    // Operand magnitude as unsigned; the most negative value maps onto itself.
    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (WIDTH'(0) - v) : v;
    endfunction

    // Multiply step: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    logic [WIDTH:0]   w_mul_sum;
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + {1'b0, r_mag_a & {WIDTH{r_mag_b[0]}}};

    // Divide step: the remainder lives in the upper half of r_acc and the
    // quotient bits shift into the lower half. r_mag_a supplies dividend bits MSB first.
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_qbit;
    logic [WIDTH-1:0] w_div_rem;
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_mag_a[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_mag_b};
    assign w_div_qbit  = ~w_div_diff[WIDTH];
    assign w_div_rem   = w_div_qbit ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];

`ifdef MDU_DIVZERO_FLAG_EN
    logic r_divzero;
    // In PREP r_mag_b still holds the raw divisor.
    assign w_dz_fast = r_op & (r_mag_b == '0);
    assign oDivZero  = (r_state == S_DONE) & r_divzero;
`else
    assign w_dz_fast = 1'b0;
`endif

    always_ff @(posedge iClk) begin
        if (iRst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (iStart) w_next = S_PREP;
            S_PREP:  w_next = w_dz_fast ? S_DONE : S_RUN;
            S_RUN:   if (r_count == CNT_W'(WIDTH - 1)) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_op     <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef MDU_DIVZERO_FLAG_EN
            r_divzero <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_op    <= iOp;
                        r_mag_a <= iRegA;
                        r_mag_b <= iRegB;
                    end
                end
                S_PREP: begin
                    r_sign_a <= r_mag_a[WIDTH-1];
                    r_sign_b <= r_mag_b[WIDTH-1];
                    r_mag_a  <= f_abs(r_mag_a);
                    r_mag_b  <= f_abs(r_mag_b);
                    r_acc    <= '0;
                    r_count  <= '0;
`ifdef MDU_DIVZERO_FLAG_EN
                    r_divzero <= w_dz_fast;
`endif
                    // Early divide-by-zero: same values the full divide would produce.
                    if (w_dz_fast) begin
                        r_hi <= r_mag_a;
                        r_lo <= r_mag_a[WIDTH-1] ? WIDTH'(1) : '1;
                    end
                end
                S_RUN: begin
                    r_count <= r_count + CNT_W'(1);
                    if (!r_op) begin
                        r_acc   <= {w_mul_sum, r_acc[WIDTH-1:1]};
                        r_mag_b <= r_mag_b >> 1;
                    end else begin
                        r_acc   <= {w_div_rem, r_acc[WIDTH-2:0], w_div_qbit};
                        r_mag_a <= r_mag_a << 1;
                    end
                end
                S_FIX: begin
                    if (!r_op) begin
                        {r_hi, r_lo} <= (r_sign_a ^ r_sign_b) ? ((2*WIDTH)'(0) - r_acc) : r_acc;
                    end else begin
                        r_lo <= (r_sign_a ^ r_sign_b) ? (WIDTH'(0) - r_acc[WIDTH-1:0])
                                                      : r_acc[WIDTH-1:0];
                        // The remainder takes the sign of the dividend.
                        r_hi <= r_sign_a ? (WIDTH'(0) - r_acc[2*WIDTH-1:WIDTH])
                                         : r_acc[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign oBusy = (r_state == S_PREP) | (r_state == S_RUN) | (r_state == S_FIX);
    assign oDone = (r_state == S_DONE);
    assign oHi   = r_hi;
    assign oLo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iStart;
    logic        iOp;
    logic [31:0] iRegA;
    logic [31:0] iRegB;
    logic        oBusy;
    logic        oDone;
    logic [31:0] oHi;
    logic [31:0] oLo;
`ifdef MDU_DIVZERO_FLAG_EN
    logic        oDivZero;
`endif

    mul_div_unit #(.WIDTH(32)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iOp     (iOp),
        .iRegA   (iRegA),
        .iRegB   (iRegB),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oHi     (oHi),
`ifdef MDU_DIVZERO_FLAG_EN
        .oLo     (oLo),
        .oDivZero(oDivZero)
`else
        .oLo     (oLo)
`endif
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          at;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;
    logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: signed arithmetic on wide integers. Integer division in SV
    // truncates toward zero, and the 64-bit width absorbs the MIN/-1 overflow.
    task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        longint      la;
        longint      lb;
        logic [63:0] r;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (!op) begin
            r  = 64'(la * lb);
            hi = r[63:32];
            lo = r[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = a[31] ? 32'd1 : 32'hFFFFFFFF;
        end else begin
            r  = 64'(la / lb);
            lo = r[31:0];
            r  = 64'(la % lb);
            hi = r[31:0];
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals completion.
    always @(negedge iClk) begin
        if (oDone) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got oDone=1 expected no completion");
            end else begin
                mon_e = sb.pop_front();
                chk("result_hi", oHi, mon_e.hi);
                chk("result_lo", oLo, mon_e.lo);
                chk("done_cycle", 32'(cyc), 32'(mon_e.at));
                chk("busy_on_done", 32'(oBusy), 32'd0);
`ifdef MDU_DIVZERO_FLAG_EN
                chk("divzero_flag", 32'(oDivZero), 32'(mon_e.dz));
`endif
                last_hi = mon_e.hi;
                last_lo = mon_e.lo;
            end
            done_cnt++;
        end
    end

    task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   d0;
        logic fast;
        @(negedge iClk);
        model(op, a, b, e.hi, e.lo);
        fast = 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
        fast = op && (b == 32'd0);
`endif
        e.dz = fast;
        e.at = cyc + (fast ? 2 : 35);
        d0 = done_cnt;
        sb.push_back(e);
        iStart = 1'b1;
        iOp    = op;
        iRegA  = a;
        iRegB  = b;
        @(negedge iClk);
        iStart = 1'b0;
        iOp    = 1'($urandom);
        iRegA  = $urandom;
        iRegB  = $urandom;
        chk("busy_after_start", 32'(oBusy), 32'd1);
        chk("hold_hi", oHi, last_hi);
        chk("hold_lo", oLo, last_lo);
        for (int k = 0; k < 50 && done_cnt == d0; k++) begin
            @(negedge iClk);
            #1;
        end
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL timeout: got no oDone within 50 cycles expected completion");
            sb.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        if ($urandom_range(3) == 0) return specials[$urandom_range(4)];
        return $urandom;
    endfunction

    initial begin
        int d0;
        iRst   = 1'b1;
        iStart = 1'b1;
        iOp    = 1'b0;
        iRegA  = 32'd5;
        iRegB  = 32'd6;
        repeat (2) @(negedge iClk);
        iRst   = 1'b0;
        iStart = 1'b0;
        chk("reset_busy", 32'(oBusy), 32'd0);
        chk("reset_done", 32'(oDone), 32'd0);
        chk("reset_hi", oHi, 32'd0);
        chk("reset_lo", oLo, 32'd0);
`ifdef MDU_DIVZERO_FLAG_EN
        chk("reset_divzero", 32'(oDivZero), 32'd0);
`endif
        @(negedge iClk);
        chk("idle_after_reset", 32'(oBusy), 32'd0);

        do_op(1'b0, 32'd7, 32'hFFFFFFFD);
        do_op(1'b0, 32'h80000000, 32'h80000000);
        do_op(1'b1, 32'hFFFFFFF9, 32'd2);
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF);
        do_op(1'b1, 32'd5, 32'd0);
        do_op(1'b1, 32'hFFFFFFFB, 32'd0);
        do_op(1'b1, 32'h80000000, 32'd0);
        do_op(1'b1, 32'd7, 32'hFFFFFFFE);

        // Reset during RUN discards the operation; a restart in RUN is ignored.
        @(negedge iClk);
        d0     = done_cnt;
        iStart = 1'b1;
        iOp    = 1'b0;
        iRegA  = 32'd3;
        iRegB  = 32'd4;
        @(negedge iClk);
        iStart = 1'b0;
        repeat (5) @(negedge iClk);
        iStart = 1'b1;
        iRegA  = 32'd100;
        iRegB  = 32'd200;
        @(negedge iClk);
        iStart = 1'b0;
        repeat (4) @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        chk("midrst_busy", 32'(oBusy), 32'd0);
        chk("midrst_done", 32'(oDone), 32'd0);
        chk("midrst_hi", oHi, 32'd0);
        chk("midrst_lo", oLo, 32'd0);
        last_hi = 32'd0;
        last_lo = 32'd0;
        repeat (45) @(negedge iClk);
        #1;
        chk("no_done_after_reset", 32'(done_cnt), 32'(d0));
        do_op(1'b0, 32'd3, 32'd4);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = pick();
            b = pick();
            do_op(1'($urandom), a, b);
        end

        repeat (3) @(negedge iClk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: got %0d pending results expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
